// File: rtl/gated_rx_master_cntrl.sv
// Rx master control: setting-bus register decode, gated decimation strobe and per-gate sample limit.
// Optional build macro GATE_ALIGN_EN: a gate rise reloads the divider so each window starts in a fixed phase.
module gated_rx_master_cntrl #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DECIM_W   = 16,
  parameter int unsigned CNT_W     = 24,
  parameter logic [6:0]  BASE_ADDR = 7'd96
) (
  input  logic               master_clk,
  input  logic               reset_n,
  input  logic [6:0]         serial_addr,
  input  logic [31:0]        serial_data,
  input  logic               serial_strobe,
  input  logic               gate_enable,
  output logic               enable_rx,
  output logic               rx_dsp_reset,
  output logic [NUM_CH-1:0]  ch_enable,
  output logic [DECIM_W-1:0] decim_rate,
  output logic               strobe_decim,
  output logic               window_done,
  output logic [CNT_W-1:0]   sample_count,
  output logic [15:0]        debug_bus
);

  // state   | meaning
  // IDLE    | rx disabled or dsp reset held; divider and count cleared
  // ARMED   | waiting for a gate rise
  // ACTIVE  | strobes pass through and are counted
  // DONE    | sample limit reached; waiting for gate low
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [6:0]         ADDR_CTRL  = BASE_ADDR;
  localparam logic [6:0]         ADDR_DECIM = BASE_ADDR + 7'd1;
  localparam logic [6:0]         ADDR_LIMIT = BASE_ADDR + 7'd2;
  localparam logic [DECIM_W-1:0] DEC_ONE    = DECIM_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  logic               r_rst_meta, r_rst_sync_n;
  logic               r_enable_rx, r_dsp_rst_req, r_dsp_rst_d1, r_dsp_rst_d2;
  logic [NUM_CH-1:0]  r_ch_enable;
  logic [DECIM_W-1:0] r_decim, r_decim_cnt;
  logic [CNT_W-1:0]   r_limit, r_sample_count;
  logic               r_gate_meta, r_gate_sync, r_gate_prev;
  state_t             r_state;

  logic               w_rst_n, w_clear, w_gate_rise, w_raw_strobe, w_strobe, w_limit_hit;
  logic [15:0]        w_cnt16;
  logic               w_unused_bits;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta   <= 1'b0;
      r_rst_sync_n <= 1'b0;
    end else begin
      r_rst_meta   <= 1'b1;
      r_rst_sync_n <= r_rst_meta;
    end
  end
  assign w_rst_n = r_rst_sync_n;

  always_ff @(posedge master_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_enable_rx   <= 1'b0;
      r_dsp_rst_req <= 1'b0;
      r_ch_enable   <= '0;
      r_decim       <= '0;
      r_limit       <= '0;
    end else if (serial_strobe) begin
      if (serial_addr == ADDR_CTRL) begin
        r_enable_rx   <= serial_data[1];
        r_dsp_rst_req <= serial_data[3];
        r_ch_enable   <= serial_data[8 +: NUM_CH];
      end
      if (serial_addr == ADDR_DECIM) r_decim <= serial_data[DECIM_W-1:0];
      if (serial_addr == ADDR_LIMIT) r_limit <= serial_data[CNT_W-1:0];
    end
  end

  always_ff @(posedge master_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_gate_meta  <= 1'b0;
      r_gate_sync  <= 1'b0;
      r_gate_prev  <= 1'b0;
      r_dsp_rst_d1 <= 1'b0;
      r_dsp_rst_d2 <= 1'b0;
    end else begin
      r_gate_meta  <= gate_enable;
      r_gate_sync  <= r_gate_meta;
      r_gate_prev  <= r_gate_sync;
      r_dsp_rst_d1 <= r_dsp_rst_req;
      r_dsp_rst_d2 <= r_dsp_rst_d1;
    end
  end

  assign w_clear      = ~r_enable_rx | r_dsp_rst_d2;
  assign w_gate_rise  = r_gate_sync & ~r_gate_prev;
  assign w_raw_strobe = ~w_clear & (r_decim_cnt == '0);
  assign w_strobe     = (r_state == ST_ACTIVE) & w_raw_strobe;
  assign w_limit_hit  = w_strobe & (r_limit != '0) & ((r_sample_count + CNT_ONE) == r_limit);

  // A rate change is picked up only at the next reload.
  always_ff @(posedge master_clk or negedge w_rst_n) begin
    if (!w_rst_n)          r_decim_cnt <= '0;
    else if (w_clear)      r_decim_cnt <= '0;
`ifdef GATE_ALIGN_EN
    else if (w_gate_rise)  r_decim_cnt <= r_decim;
`endif
    else if (w_raw_strobe) r_decim_cnt <= r_decim;
    else                   r_decim_cnt <= r_decim_cnt - DEC_ONE;
  end

  always_ff @(posedge master_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state        <= ST_IDLE;
      r_sample_count <= '0;
    end else if (w_clear) begin
      r_state        <= ST_IDLE;
      r_sample_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_ARMED;
        ST_ARMED: begin
          if (w_gate_rise) begin
            r_state        <= ST_ACTIVE;
            r_sample_count <= '0;
          end
        end
        ST_ACTIVE: begin
          if (w_strobe && (r_sample_count != '1)) r_sample_count <= r_sample_count + CNT_ONE;
          // Gate loss wins over the limit so a coincident last strobe still re-arms.
          if (!r_gate_sync)     r_state <= ST_ARMED;
          else if (w_limit_hit) r_state <= ST_DONE;
        end
        ST_DONE: if (!r_gate_sync) r_state <= ST_ARMED;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_cnt16       = 16'(r_decim_cnt);
  assign w_unused_bits = ^{serial_data, w_cnt16[15:8]};

  assign enable_rx    = r_enable_rx;
  assign rx_dsp_reset = r_dsp_rst_d2;
  assign ch_enable    = r_ch_enable;
  assign decim_rate   = r_decim;
  assign strobe_decim = w_strobe;
  assign window_done  = w_limit_hit;
  assign sample_count = r_sample_count;
  assign debug_bus    = {r_state, r_gate_sync, w_gate_rise, w_raw_strobe, 3'b000, w_cnt16[7:0]};

endmodule

// File: tb/tb_gated_rx_master_cntrl.sv
// Bench for gated_rx_master_cntrl: directed and random gate windows checked against an arithmetic strobe model.
// Build with GATE_ALIGN_EN defined to check the aligned-phase variant.
module tb_gated_rx_master_cntrl;
  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned DECIM_W = 16;
  localparam int unsigned CNT_W   = 5;
  localparam logic [6:0]  A_CTRL  = 7'd96;
  localparam logic [6:0]  A_DECIM = 7'd97;
  localparam logic [6:0]  A_LIMIT = 7'd98;

  logic               master_clk = 1'b0;
  logic               reset_n = 1'b1;
  logic [6:0]         serial_addr = '0;
  logic [31:0]        serial_data = '0;
  logic               serial_strobe = 1'b0;
  logic               gate_enable = 1'b0;
  logic               enable_rx, rx_dsp_reset, strobe_decim, window_done;
  logic [NUM_CH-1:0]  ch_enable;
  logic [DECIM_W-1:0] decim_rate;
  logic [CNT_W-1:0]   sample_count;
  logic [15:0]        debug_bus;

  gated_rx_master_cntrl #(
    .NUM_CH(NUM_CH), .DECIM_W(DECIM_W), .CNT_W(CNT_W), .BASE_ADDR(A_CTRL)
  ) dut (
    .master_clk(master_clk), .reset_n(reset_n), .serial_addr(serial_addr),
    .serial_data(serial_data), .serial_strobe(serial_strobe), .gate_enable(gate_enable),
    .enable_rx(enable_rx), .rx_dsp_reset(rx_dsp_reset), .ch_enable(ch_enable),
    .decim_rate(decim_rate), .strobe_decim(strobe_decim), .window_done(window_done),
    .sample_count(sample_count), .debug_bus(debug_bus)
  );

  always #5 master_clk = ~master_clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int c_en = 0;
  int cur_d = 0;
  int last_g = 0;
  int last_n = 0;
  int first_strb = -1;
  int q_strb[$];
  int q_wd[$];

  always @(posedge master_clk) cyc <= cyc + 1;

  always @(negedge master_clk) begin
    if (reset_n && strobe_decim) q_strb.push_back(cyc);
    if (reset_n && window_done)  q_wd.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    serial_addr   = a;
    serial_data   = d;
    serial_strobe = 1'b1;
    @(negedge master_clk);
    serial_strobe = 1'b0;
  endtask

  task automatic setup(input int d, input int lim, input logic [3:0] ch);
    wr(A_CTRL, 32'h0);
    wr(A_DECIM, 32'(d));
    wr(A_LIMIT, 32'(lim));
    wr(A_CTRL, {20'h0, ch, 8'h02});
    c_en  = cyc;
    cur_d = d;
    chk("enable_rx", 64'(enable_rx), 64'd1);
    chk("ch_enable", 64'(ch_enable), 64'(ch));
    chk("decim_rate", 64'(decim_rate), 64'(d));
    repeat (4) @(negedge master_clk);
  endtask

  // Gate held high for h cycles; strobes are predicted for the h active cycles that follow the synchroniser.
  task automatic run_window(input int h, input int lim, input int mid_at, input int mid_val);
    int g, a, p, ewd, ecnt, cmax;
    int e_q[$];
    q_strb.delete();
    q_wd.delete();
    gate_enable = 1'b1;
    g = cyc;
    a = g + 3;
    p = cur_d + 1;
    for (int k = 0; k < h; k++) begin
      if (mid_at != 0 && k == mid_at) wr(A_LIMIT, 32'(mid_val));
      else @(negedge master_clk);
    end
    gate_enable = 1'b0;
    repeat (6) @(negedge master_clk);
    for (int t = a; t < a + h; t++) begin
`ifdef GATE_ALIGN_EN
      if ((t - a) >= cur_d && ((t - a - cur_d) % p) == 0) e_q.push_back(t);
`else
      if (((t - c_en) % p) == 0) e_q.push_back(t);
`endif
    end
    if (lim != 0) while (e_q.size() > lim) void'(e_q.pop_back());
    chk("n_strobe", 64'(q_strb.size()), 64'(e_q.size()));
    for (int i = 0; i < e_q.size(); i++)
      if (i < q_strb.size()) chk("strobe_cycle", 64'(q_strb[i]), 64'(e_q[i]));
    ewd = (lim != 0 && e_q.size() == lim) ? 1 : 0;
    chk("n_window_done", 64'(q_wd.size()), 64'(ewd));
    if (ewd == 1 && q_wd.size() == 1) chk("window_done_cycle", 64'(q_wd[0]), 64'(e_q[lim-1]));
    cmax = (1 << CNT_W) - 1;
    ecnt = e_q.size();
    if (lim == 0 && ecnt > cmax) ecnt = cmax;
    chk("sample_count", 64'(sample_count), 64'(ecnt));
    last_g     = g;
    last_n     = q_strb.size();
    first_strb = (q_strb.size() > 0) ? q_strb[0] : -1;
  endtask

  initial begin
    int off;
    #3 reset_n = 1'b0;
    repeat (2) @(negedge master_clk);
    chk("rst_enable_rx", 64'(enable_rx), 64'd0);
    chk("rst_dsp_reset", 64'(rx_dsp_reset), 64'd0);
    chk("rst_ch_enable", 64'(ch_enable), 64'd0);
    chk("rst_decim_rate", 64'(decim_rate), 64'd0);
    chk("rst_strobe", 64'(strobe_decim), 64'd0);
    chk("rst_window_done", 64'(window_done), 64'd0);
    chk("rst_sample_count", 64'(sample_count), 64'd0);
    chk("rst_debug_bus", 64'(debug_bus), 64'd0);
    #3 reset_n = 1'b1;
    repeat (5) @(negedge master_clk);
    chk("post_rst_debug_bus", 64'(debug_bus), 64'd0);

    // register decode: truncation and foreign addresses
    wr(A_DECIM, 32'hABCD_0003);
    chk("decim_trunc", 64'(decim_rate), 64'h3);
    wr(7'd99, 32'hFFFF_FFFF);
    wr(7'd95, 32'hFFFF_FFFF);
    chk("foreign_decim", 64'(decim_rate), 64'h3);
    chk("foreign_enable", 64'(enable_rx), 64'd0);
    chk("foreign_ch", 64'(ch_enable), 64'd0);
    wr(A_CTRL, 32'hFFFF_F5F2);
    chk("ctrl_enable", 64'(enable_rx), 64'd1);
    chk("ctrl_ch", 64'(ch_enable), 64'h5);
    chk("ctrl_dsp_reset", 64'(rx_dsp_reset), 64'd0);

    // rate 4, one strobe every 5 active cycles
    setup(4, 0, 4'hF);
    run_window(40, 0, 0, 0);
    chk("t1_n", 64'(last_n), 64'd8);

    // rate 0, strobe every cycle of a 20-cycle window
    setup(0, 0, 4'hF);
    run_window(20, 0, 0, 0);
    chk("t6_count", 64'(sample_count), 64'd20);

    // saturation with no limit
    setup(0, 0, 4'hA);
    run_window(40, 0, 0, 0);
    chk("sat_count", 64'(sample_count), 64'd31);

    // limit 3 over two long gates
    setup(1, 3, 4'hF);
    repeat (3) @(negedge master_clk);
    run_window(100, 3, 0, 0);
    chk("t2_first_n", 64'(last_n), 64'd3);
    repeat (4) @(negedge master_clk);
    run_window(100, 3, 0, 0);
    chk("t2_second_n", 64'(last_n), 64'd3);

    // limit strobe on the same cycle the gate falls
    setup(0, 8, 4'hF);
    run_window(8, 8, 0, 0);

    // window length where a strobe may land on the falling cycle
    setup(3, 0, 4'hF);
    repeat (2) @(negedge master_clk);
    run_window(8, 0, 0, 0);

    // limit lowered below the running count: no window_done
    setup(0, 0, 4'hF);
    run_window(30, 0, 15, 3);

    // first-strobe phase at rate 9
    setup(9, 0, 4'hF);
    for (int tr = 0; tr < 5; tr++) begin
      repeat ($urandom_range(1, 12)) @(negedge master_clk);
      run_window(25, 0, 0, 0);
      off = first_strb - (last_g + 2);
`ifdef GATE_ALIGN_EN
      chk("t3_first_offset", 64'(off), 64'd10);
`else
      chk("t3_offset_range", 64'(off >= 1 && off <= 10), 64'd1);
`endif
    end

    // dsp reset mid-window
    setup(2, 0, 4'hF);
    repeat (3) @(negedge master_clk);
    gate_enable = 1'b1;
    repeat (12) @(negedge master_clk);
    wr(A_CTRL, 32'h0000_0F0A);
    chk("t4_dsp_d0", 64'(rx_dsp_reset), 64'd0);
    @(negedge master_clk);
    chk("t4_dsp_d1", 64'(rx_dsp_reset), 64'd0);
    @(negedge master_clk);
    chk("t4_dsp_d2", 64'(rx_dsp_reset), 64'd1);
    chk("t4_strobe_masked", 64'(strobe_decim), 64'd0);
    @(negedge master_clk);
    chk("t4_count_clear", 64'(sample_count), 64'd0);
    chk("t4_state_idle", 64'(debug_bus[15:14]), 64'd0);
    q_strb.delete();
    repeat (10) @(negedge master_clk);
    chk("t4_no_strobes", 64'(q_strb.size()), 64'd0);
    gate_enable = 1'b0;

    // async reset in the middle of a window
    setup(1, 0, 4'hF);
    repeat (3) @(negedge master_clk);
    gate_enable = 1'b1;
    repeat (10) @(negedge master_clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_enable_rx", 64'(enable_rx), 64'd0);
    chk("t5_dsp_reset", 64'(rx_dsp_reset), 64'd0);
    chk("t5_ch_enable", 64'(ch_enable), 64'd0);
    chk("t5_decim_rate", 64'(decim_rate), 64'd0);
    chk("t5_strobe", 64'(strobe_decim), 64'd0);
    chk("t5_window_done", 64'(window_done), 64'd0);
    chk("t5_sample_count", 64'(sample_count), 64'd0);
    chk("t5_debug_bus", 64'(debug_bus), 64'd0);
    gate_enable = 1'b0;
    repeat (3) @(negedge master_clk);
    #3 reset_n = 1'b1;
    repeat (5) @(negedge master_clk);
    chk("t5_after_state", 64'(debug_bus[15:14]), 64'd0);
    chk("t5_after_enable", 64'(enable_rx), 64'd0);
    chk("t5_after_count", 64'(sample_count), 64'd0);

    // random configurations and window lengths
    for (int tr = 0; tr < 12; tr++) begin
      int d, lim, h;
      logic [3:0] ch;
      d   = $urandom_range(0, 6);
      lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
      h   = $urandom_range(4, 40);
      ch  = 4'($urandom_range(0, 15));
      setup(d, lim, ch);
      repeat ($urandom_range(2, 9)) @(negedge master_clk);
      run_window(h, lim, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
